board_move_collector: RTL and testbench
=======================================

# board_move_collector

Board-level controller that sequences one move-generation pass across the eight column units and funnels their per-column move FIFOs into a single move stream. It pulses the column reset on start, then round-robin arbitrates among non-empty column FIFOs. It pops one 19-bit move word at a time and presents it on a valid/ready output port. It signals pass completion once every column reports done and all FIFOs are drained. It sits between the column array and the downstream move consumer (evaluator / host bridge).

## Interface
- NCOL, 8, number of column units arbitrated
- MW, 19, move word width: [18:12] flags {invalid, promote, pawn move, pawn 2 sq, en passant, castle, capture}, [11:6] from, [5:0] to
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a pass; sampled only in IDLE or DONE
- busy  out  1  high in every state except IDLE and DONE
- all_done  out  1  high in DONE
- col_rst  out  NCOL  reset to column units, all bits driven together
- col_done  in  NCOL  per-column done flag
- col_empty  in  NCOL  per-column FIFO empty flag
- col_rden  out  NCOL  per-column FIFO read enable, at most one bit high
- col_data  in  NCOL*MW  column FIFO read data, column i at [i*MW +: MW]; valid the cycle after col_rden[i]
- m_valid  out  1  output move valid
- m_ready  in  1  consumer accepts move
- m_data  out  MW  output move
- move_count  out  8  moves forwarded this pass, saturates at 255

## Operation
- States: IDLE, CLR, SCAN, READ, CAPT, OUT, DONE. All outputs are registered.
- IDLE: start=1 moves to CLR. It also clears move_count and sets the round-robin pointer ptr to 0.
- CLR: lasts exactly 2 cycles with col_rst all ones, then moves to SCAN.
- SCAN, completion check: if &col_done and &col_empty, go to DONE. This takes priority over the grant.
- SCAN, grant: otherwise, grant g = the first i in ptr, ptr+1, … (mod NCOL) with col_empty[i]=0, then go to READ. If no column is eligible, stay in SCAN.
- READ: col_rden[g]=1 for exactly one cycle, then CAPT.
- CAPT: m_data ← col_data[g], then OUT.
- OUT: m_valid=1 with m_data held stable until m_ready=1.
- OUT handshake: on the cycle m_valid & m_ready, ptr ← (g+1) mod NCOL, move_count increments (saturating), then SCAN.
- DONE: all_done=1. start=1 moves to CLR, which clears move_count and resets ptr=0.
- start in any state other than IDLE and DONE is ignored.
- This block is the only reader of the column FIFOs. A column granted in SCAN stays non-empty through READ; no re-check is made.
- A column may assert done while its FIFO is still non-empty. It remains eligible until drained.

## Timing
- Reset (async): state=IDLE, ptr=0. busy, all_done, col_rst, col_rden, m_valid, m_data and move_count are all 0.
- Reset mid-pass drops any in-flight move and deasserts col_rden the same instant.
- Start to first possible grant: start sampled in cycle 0; CLR occupies cycles 1–2; first SCAN in cycle 3.
- Minimum per-move latency from a SCAN grant: col_rden high 1 cycle later, m_valid high 3 cycles later.
- Throughput: one move per 4 cycles with m_ready held high.
- Completion: all_done rises the cycle after the SCAN that sees all columns done and all FIFOs empty.
- A move in OUT is never lost or changed by col_done or col_empty activity.

## Configuration
- MOVE_FILTER_INVALID_EN defined: in CAPT, a word with flag bit [18]=1 is discarded.
  - m_valid is not asserted.
  - ptr ← g+1, move_count is unchanged, next state is SCAN.
- MOVE_FILTER_INVALID_EN undefined: every popped word is forwarded unchanged, including invalid-flagged words.

## Test plan
- Reset/idle: assert reset asynchronously mid-OUT → m_valid and col_rden drop immediately; all outputs read 0; state returns to IDLE.
- Start sequencing: pulse start → col_rst=8'hFF for exactly 2 cycles; busy=1; first col_rden no earlier than 4 cycles after start.
- Round-robin fairness: columns 0, 3 and 7 each hold 2 moves with m_ready=1 → pop order is 0,3,7,0,3,7; move_count=6; then all_done=1 once col_done=8'hFF.
- Backpressure: m_ready=0 for 10 cycles while in OUT → m_valid stays 1, m_data stays stable, no col_rden pulses; on m_ready=1 the handshake occurs and move_count increments by 1.
- Done/non-empty overlap: col_done=8'hFF with column 5 still holding 1 move (e.g. 19'h0_0A_1C) → that move is output first, then all_done asserts.
- Filter (macro defined): column 2 holds 19'h40000 then 19'h01041 → only 19'h01041 is output; move_count=1. With the macro undefined, both words are output and move_count=2.

Source files
------------

// File: rtl/board_move_collector_if.sv
// Move stream between board_move_collector and the downstream consumer.
// Handshake: a move transfers on any rising clk edge where m_valid and m_ready are both high;
// while m_valid is high, m_data is held stable and m_valid is not withdrawn until the transfer.
interface board_move_collector_if #(
    parameter int MW = 19
);
    logic          m_valid;
    logic          m_ready;
    logic [MW-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/board_move_collector.sv
// Sequences one move-generation pass over the column units and merges their FIFOs into one move stream.
// Optional feature macro MOVE_FILTER_INVALID_EN: words with the invalid flag (bit MW-1) are dropped in CAPT.
module board_move_collector #(
    parameter int NCOL = 8,
    parameter int MW   = 19
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   all_done,
    output logic [NCOL-1:0]        col_rst,
    input  logic [NCOL-1:0]        col_done,
    input  logic [NCOL-1:0]        col_empty,
    output logic [NCOL-1:0]        col_rden,
    input  logic [NCOL*MW-1:0]     col_data,
    output logic [7:0]             move_count,
    output logic [2:0]             state_dbg,
    board_move_collector_if.master mv
);
    localparam int PW = (NCOL > 1) ? $clog2(NCOL) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        SCAN = 3'd2,
        READ = 3'd3,
        CAPT = 3'd4,
        OUT  = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] ptr;
    logic [PW-1:0] g;
    logic [PW-1:0] g_inc;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] scan_idx;
    logic          grant_found;
    logic          clr_last;
    logic [MW-1:0] capt_word;
    logic          drop_word;

    assign state_dbg = state;
    assign capt_word = col_data[g*MW +: MW];
    assign g_inc     = PW'((int'(g) + 1) % NCOL);

`ifdef MOVE_FILTER_INVALID_EN
    assign drop_word = capt_word[MW-1];
`else
    assign drop_word = 1'b0;
`endif

    // First non-empty column at or after ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NCOL; k++) begin
            scan_idx = PW'((int'(ptr) + k) % NCOL);
            if (!grant_found && !col_empty[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = CLR;
            CLR:  if (clr_last) state_nx = SCAN;
            SCAN: begin
                if ((&col_done) && (&col_empty)) state_nx = DONE;
                else if (grant_found)            state_nx = READ;
            end
            READ: state_nx = CAPT;
            CAPT: state_nx = drop_word ? SCAN : OUT;
            OUT:  if (mv.m_ready) state_nx = SCAN;
            DONE: if (start) state_nx = CLR;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Outputs are decoded from the next state so they are flops aligned with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            g          <= '0;
            clr_last   <= 1'b0;
            busy       <= 1'b0;
            all_done   <= 1'b0;
            col_rst    <= '0;
            col_rden   <= '0;
            mv.m_valid <= 1'b0;
            mv.m_data  <= '0;
            move_count <= '0;
        end else begin
            busy       <= (state_nx != IDLE) && (state_nx != DONE);
            all_done   <= (state_nx == DONE);
            col_rst    <= {NCOL{state_nx == CLR}};
            col_rden   <= '0;
            mv.m_valid <= (state_nx == OUT);
            clr_last   <= (state == CLR) && !clr_last;

            if ((state == IDLE || state == DONE) && start) begin
                ptr        <= '0;
                move_count <= '0;
            end

            if (state == SCAN && state_nx == READ) begin
                g        <= grant_idx;
                col_rden <= NCOL'(1) << grant_idx;
            end

            if (state == CAPT) begin
                if (drop_word) ptr <= g_inc;
                else           mv.m_data <= capt_word;
            end

            if (state == OUT && mv.m_ready) begin
                ptr <= g_inc;
                if (move_count != 8'hFF) move_count <= move_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_board_move_collector.sv
`timescale 1ns/1ps
// Bench for board_move_collector: start-sequence vector table, directed corner cases, randomized passes vs. a round-robin model.
module tb_board_move_collector;
    localparam int NCOL  = 8;
    localparam int MW    = 19;
    localparam int DEPTH = 64;
    localparam int MAXW  = 40;
`ifdef MOVE_FILTER_INVALID_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic               clk      = 1'b0;
    logic               reset    = 1'b1;
    logic               start    = 1'b0;
    logic               busy;
    logic               all_done;
    logic [NCOL-1:0]    col_rst;
    logic [NCOL-1:0]    col_rden;
    logic [NCOL-1:0]    col_done = '0;
    logic [NCOL-1:0]    col_empty;
    logic [NCOL*MW-1:0] col_data = '0;
    logic [7:0]         move_count;
    logic [2:0]         state_dbg;

    int checks     = 0;
    int failures   = 0;
    int handshakes = 0;
    logic [MW-1:0] exp_q[$];

    board_move_collector_if #(.MW(MW)) mv();

    board_move_collector #(.NCOL(NCOL), .MW(MW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .all_done(all_done),
        .col_rst(col_rst), .col_done(col_done), .col_empty(col_empty), .col_rden(col_rden),
        .col_data(col_data), .move_count(move_count), .state_dbg(state_dbg), .mv(mv)
    );

    always #5 clk = ~clk;

    // ---------------- column FIFO model ----------------
    logic [MW-1:0] fmem [NCOL][DEPTH];
    int frd [NCOL] = '{default: 0};
    int fwr [NCOL] = '{default: 0};

    always_comb begin
        for (int i = 0; i < NCOL; i++) col_empty[i] = (frd[i] == fwr[i]);
    end

    always @(posedge clk) begin
        if (col_rden !== '0) begin
            checks++;
            if ($countones(col_rden) != 1 || (col_rden & col_empty) != '0) begin
                failures++;
                $display("FAIL col_rden_legal actual=%b empty=%b required=one-hot on non-empty", col_rden, col_empty);
            end
        end
        for (int i = 0; i < NCOL; i++) begin
            if (col_rden[i] === 1'b1 && frd[i] != fwr[i]) begin
                col_data[i*MW +: MW] <= fmem[i][frd[i] % DEPTH];
                frd[i] <= frd[i] + 1;
            end
        end
    end

    task automatic push_word(input int c, input logic [MW-1:0] w);
        fmem[c][fwr[c] % DEPTH] = w;
        fwr[c] = fwr[c] + 1;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NCOL; i++) fwr[i] = frd[i];
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: every transfer must match the head of exp_q.
    always begin
        @(negedge clk);
        #2;
        if (mv.m_valid === 1'b1 && mv.m_ready === 1'b1) begin
            handshakes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL m_data_extra actual=0x%0h required=no move", mv.m_data);
            end else begin
                check("m_data_order", 32'(mv.m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready, input string name);
        int n = 0;
        while (all_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            if (rand_ready) mv.m_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check(name, 32'(all_done), 1);
        mv.m_ready = 1'b1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (mv.m_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(mv.m_valid), 1);
    endtask

    // Fills the column FIFOs and derives the expected stream from the round-robin rule.
    task automatic build_pass(input int lo, input int hi, input bit allow_invalid, output int exp_cnt);
        logic [MW-1:0] mw [NCOL][MAXW];
        int mcnt [NCOL];
        int mpos [NCOL];
        int remaining, ptr, col, fwd;
        bit found;
        logic [MW-1:0] w;
        remaining = 0;
        for (int c = 0; c < NCOL; c++) begin
            mcnt[c] = int'($urandom_range(hi, lo));
            mpos[c] = 0;
            for (int j = 0; j < mcnt[c]; j++) begin
                w = MW'($urandom);
                w[MW-1] = allow_invalid && ($urandom_range(0, 3) == 0);
                mw[c][j] = w;
                push_word(c, w);
            end
            remaining += mcnt[c];
        end
        ptr = 0;
        fwd = 0;
        while (remaining > 0) begin
            found = 1'b0;
            for (int k = 0; k < NCOL && !found; k++) begin
                col = (ptr + k) % NCOL;
                if (mpos[col] < mcnt[col]) begin
                    w = mw[col][mpos[col]];
                    mpos[col]++;
                    remaining--;
                    found = 1'b1;
                    ptr = (col + 1) % NCOL;
                    if (!(FILTER && w[MW-1])) begin
                        exp_q.push_back(w);
                        fwd++;
                    end
                end
            end
        end
        exp_cnt = (fwd > 255) ? 255 : fwd;
    endtask

    // ---------------- start-sequence vector table ----------------
    typedef struct packed {
        logic       busy;
        logic       all_done;
        logic [7:0] col_rst;
        logic [7:0] col_rden;
        logic       m_valid;
        logic [7:0] move_count;
    } seq_rec_t;

    seq_rec_t seq_tab [8];
    int       rr_cols [3];

    initial begin
        int h0, n, exp_cnt;
        logic [MW-1:0] w;

        // One move in column 0, m_ready high, all columns done: sampled one cycle at a time after start.
        seq_tab[0] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'd0};
        seq_tab[1] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'd0};
        seq_tab[2] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0};
        seq_tab[3] = '{1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 8'd0};
        seq_tab[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0};
        seq_tab[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'd0};
        seq_tab[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd1};
        seq_tab[7] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'd1};
        rr_cols = '{0, 3, 7};

        mv.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_all_done", 32'(all_done), 0);
        check("rst_col_rst", 32'(col_rst), 0);
        check("rst_col_rden", 32'(col_rden), 0);
        check("rst_m_valid", 32'(mv.m_valid), 0);
        check("rst_m_data", 32'(mv.m_data), 0);
        check("rst_move_count", 32'(move_count), 0);
        check("rst_state", 32'(state_dbg), 0);
        reset = 1'b0;

        // Round-robin fairness across columns 0, 3, 7.
        col_done = '0;
        mv.m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                w = {7'd0, 6'(rr_cols[i]), 6'(k)};
                push_word(rr_cols[i], w);
                exp_q.push_back(w);
            end
        end
        h0 = handshakes;
        pulse_start();
        n = 0;
        while (handshakes < h0 + 6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rr_moves", 32'(handshakes - h0), 6);
        repeat (4) @(negedge clk);
        check("rr_not_done", 32'(all_done), 0);
        check("rr_busy", 32'(busy), 1);
        check("rr_count", 32'(move_count), 6);
        col_done = '1;
        wait_done(20, 1'b0, "rr_done");
        check("rr_queue_empty", 32'(exp_q.size()), 0);

        // Cycle-by-cycle start sequencing from the vector table.
        push_word(0, 19'h01234);
        exp_q.push_back(19'h01234);
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("seq[%0d]", k),
                  32'({busy, all_done, col_rst, col_rden, mv.m_valid, move_count}), 32'(seq_tab[k]));
        end
        check("seq_queue_empty", 32'(exp_q.size()), 0);

        // Backpressure: move held in OUT for 10 cycles.
        push_word(1, 19'h2ABCD);
        exp_q.push_back(19'h2ABCD);
        mv.m_ready = 1'b0;
        pulse_start();
        wait_valid(20, "bp_reach_out");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_m_valid", 32'(mv.m_valid), 1);
            check("bp_m_data", 32'(mv.m_data), 32'h2ABCD);
            check("bp_col_rden", 32'(col_rden), 0);
        end
        h0 = handshakes;
        mv.m_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake", 32'(handshakes - h0), 1);
        check("bp_count", 32'(move_count), 1);
        wait_done(20, 1'b0, "bp_done");

        // Column reports done while still holding a move.
        push_word(5, 19'h00A1C);
        exp_q.push_back(19'h00A1C);
        h0 = handshakes;
        pulse_start();
        wait_done(30, 1'b0, "ovl_done");
        check("ovl_moves_before_done", 32'(handshakes - h0), 1);
        check("ovl_count", 32'(move_count), 1);

        // Invalid-flagged word handling.
        push_word(2, 19'h40000);
        push_word(2, 19'h01041);
        if (!FILTER) exp_q.push_back(19'h40000);
        exp_q.push_back(19'h01041);
        pulse_start();
        wait_done(40, 1'b0, "flt_done");
        check("flt_count", 32'(move_count), FILTER ? 1 : 2);
        check("flt_queue_empty", 32'(exp_q.size()), 0);

        // Asynchronous reset in the middle of OUT.
        col_done = '0;
        push_word(4, 19'h12345);
        mv.m_ready = 1'b0;
        pulse_start();
        wait_valid(20, "rst_out_reach");
        #3 reset = 1'b1;
        #1;
        check("rst_out_m_valid", 32'(mv.m_valid), 0);
        check("rst_out_col_rden", 32'(col_rden), 0);
        check("rst_out_busy", 32'(busy), 0);
        check("rst_out_m_data", 32'(mv.m_data), 0);
        check("rst_out_count", 32'(move_count), 0);
        check("rst_out_state", 32'(state_dbg), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_fifos();

        // Asynchronous reset while col_rden is high.
        push_word(6, 19'h00777);
        mv.m_ready = 1'b1;
        pulse_start();
        n = 0;
        while (col_rden === '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_rd_reach", 32'(col_rden), 32'h40);
        #3 reset = 1'b1;
        #1;
        check("rst_rd_col_rden", 32'(col_rden), 0);
        check("rst_rd_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_fifos();
        exp_q.delete();

        // Randomized passes with random backpressure.
        col_done = '1;
        for (int it = 0; it < 15; it++) begin
            build_pass(0, 4, 1'b1, exp_cnt);
            pulse_start();
            wait_done(1000, 1'b1, $sformatf("rnd_done[%0d]", it));
            check($sformatf("rnd_count[%0d]", it), 32'(move_count), 32'(exp_cnt));
            check($sformatf("rnd_queue_empty[%0d]", it), 32'(exp_q.size()), 0);
        end

        // move_count saturation: 264 valid moves in one pass.
        mv.m_ready = 1'b1;
        build_pass(33, 33, 1'b0, exp_cnt);
        pulse_start();
        wait_done(2000, 1'b0, "sat_done");
        check("sat_count", 32'(move_count), 255);
        check("sat_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
